// File: rtl/banana_collision_detector.sv
// Detects player/banana pixel overlap per video frame and reports it at the next startOfFrame.
// Define BANANA_COLLISION_EDGE_OR_EN to report the union of all edge codes touched in the frame.
module banana_collision_detector #(
  parameter int COUNT_W         = 8,
  parameter int MIN_OVERLAP_PIX = 1
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               enable,
  input  logic               playerDR,
  input  logic [3:0]         playerHitEdgeCode,
  input  logic               bananaDR,
  input  logic               clearCount,
  output logic               collisionPulse,
  output logic [3:0]         collisionEdgeCode,
  output logic [COUNT_W-1:0] catchCount,
  output logic               frameHitActive
);

  typedef enum logic [1:0] {IDLE, ARMED, HIT} state_t;

  localparam logic [7:0] MinPix = 8'(MIN_OVERLAP_PIX);

  state_t               state_q, state_d;
  logic [7:0]           pix_cnt_q, pix_cnt_d;
  logic [3:0]           edge_acc_q, edge_acc_d;
  logic                 collision_pulse_q;
  logic [3:0]           collision_edge_q;
  logic [COUNT_W-1:0]   catch_count_q;
  logic                 ovl;
  logic                 report_hit;
  logic                 counting;
  logic [7:0]           pix_inc;

  assign ovl = enable & playerDR & bananaDR;

  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    edge_acc_d = edge_acc_q;
    report_hit = 1'b0;
    counting   = 1'b0;
    pix_inc    = 8'd0;

    // A startOfFrame closes the old frame first; a coincident overlap pixel belongs to the new one.
    case (state_q)
      IDLE: begin
        if (startOfFrame) begin
          state_d    = ARMED;
          pix_cnt_d  = 8'd0;
          edge_acc_d = 4'h0;
          counting   = 1'b1;
        end
      end
      ARMED, HIT: begin
        if (startOfFrame) begin
          report_hit = (state_q == HIT);
          state_d    = ARMED;
          pix_cnt_d  = 8'd0;
          edge_acc_d = 4'h0;
          counting   = 1'b1;
        end else begin
          counting = (state_q == ARMED);
        end
      end
      default: state_d = IDLE;
    endcase

    pix_inc = (pix_cnt_d == 8'hFF) ? pix_cnt_d : pix_cnt_d + 8'd1;

    if (ovl && counting) begin
`ifdef BANANA_COLLISION_EDGE_OR_EN
      edge_acc_d = edge_acc_d | playerHitEdgeCode;
`else
      if (pix_cnt_d == 8'd0) begin
        edge_acc_d = playerHitEdgeCode;
      end
`endif
      pix_cnt_d = pix_inc;
      if (pix_inc >= MinPix) begin
        state_d = HIT;
      end
    end
`ifdef BANANA_COLLISION_EDGE_OR_EN
    else if (ovl && state_q == HIT) begin
      edge_acc_d = edge_acc_d | playerHitEdgeCode;
    end
`endif
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q           <= IDLE;
      pix_cnt_q         <= 8'd0;
      edge_acc_q        <= 4'h0;
      collision_pulse_q <= 1'b0;
      collision_edge_q  <= 4'h0;
      catch_count_q     <= '0;
    end else begin
      state_q           <= state_d;
      pix_cnt_q         <= pix_cnt_d;
      edge_acc_q        <= edge_acc_d;
      collision_pulse_q <= report_hit;
      if (report_hit) begin
        collision_edge_q <= edge_acc_q;
      end
      // Clear wins over a simultaneous increment.
      if (clearCount) begin
        catch_count_q <= '0;
      end else if (report_hit && (catch_count_q != '1)) begin
        catch_count_q <= catch_count_q + COUNT_W'(1);
      end
    end
  end

  assign collisionPulse    = collision_pulse_q;
  assign collisionEdgeCode = collision_edge_q;
  assign catchCount        = catch_count_q;
  assign frameHitActive    = (state_q == HIT);

endmodule
